// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger game-control logic.
package frogger_pkg;

   localparam int unsigned c_TILE_W      = 6;
   localparam int unsigned c_SCORE_W     = 7;
   localparam int unsigned c_BOARD_COLS  = 20;
   localparam int unsigned c_BOARD_ROWS  = 15;
   localparam int unsigned c_TILE_PIXELS = 32;

   typedef logic [c_TILE_W-1:0]  tile_t;
   typedef logic [c_TILE_W:0]    tile_ext_t;
   typedef logic [c_SCORE_W-1:0] score_t;
   typedef logic [2:0]           state_t;

   localparam state_t IDLE      = 3'b000;
   localparam state_t RUNNING   = 3'b001;
   localparam state_t HIT       = 3'b010;
   localparam state_t GAME_OVER = 3'b011;
   localparam state_t WIN       = 3'b100;
   localparam state_t CLEANUP   = 3'b101;

endpackage

// File: rtl/frogger_game_fsm_if.sv
// Game-control bus: world positions and frame timing in, game status and respawn out.
interface frogger_game_fsm_if;
   import frogger_pkg::*;

   logic       i_VSync;
   logic       i_Game_Start;
   tile_t      i_Frogger_X;
   tile_t      i_Frogger_Y;
   tile_t      i_Car_X_1;
   tile_t      i_Car_Y_1;
   tile_t      i_Car_X_2;
   tile_t      i_Car_Y_2;
   tile_t      i_Car_X_3;
   tile_t      i_Car_Y_3;
   logic       o_Game_Active;
   score_t     o_Score;
   logic [1:0] o_Lives;
   logic       o_Frog_Reset;
   state_t     o_State;

   modport master (
      output i_VSync, i_Game_Start, i_Frogger_X, i_Frogger_Y,
             i_Car_X_1, i_Car_Y_1, i_Car_X_2, i_Car_Y_2, i_Car_X_3, i_Car_Y_3,
      input  o_Game_Active, o_Score, o_Lives, o_Frog_Reset, o_State
   );

   modport slave (
      input  i_VSync, i_Game_Start, i_Frogger_X, i_Frogger_Y,
             i_Car_X_1, i_Car_Y_1, i_Car_X_2, i_Car_Y_2, i_Car_X_3, i_Car_Y_3,
      output o_Game_Active, o_Score, o_Lives, o_Frog_Reset, o_State
   );

endinterface

// File: rtl/car_collision_check.sv
// Combinational frog/car overlap test for a single car spanning c_CAR_WIDTH tiles.
module car_collision_check
   import frogger_pkg::*;
#(
   parameter int unsigned c_CAR_WIDTH = 1
) (
   input  tile_t i_Frogger_X,
   input  tile_t i_Frogger_Y,
   input  tile_t i_Car_X,
   input  tile_t i_Car_Y,
   output logic  o_Hit
);

   // One extra bit so a car near the right board edge cannot wrap its end to 0.
   tile_ext_t car_end;

   assign car_end = {1'b0, i_Car_X} + tile_ext_t'(c_CAR_WIDTH);
   assign o_Hit   = (i_Frogger_Y == i_Car_Y) &&
                    (i_Frogger_X >= i_Car_X) &&
                    ({1'b0, i_Frogger_X} < car_end);

endmodule

// File: rtl/frogger_game_fsm.sv
// Frogger game-control FSM: start, scoring, death/respawn, evaluated once per VSync frame.
// Define FROGGER_LIVES_EN for multi-life play; otherwise the first death ends the game.
module frogger_game_fsm
   import frogger_pkg::*;
#(
   parameter int unsigned c_SCORE_LIMIT  = 99,
   parameter int unsigned c_GOAL_ROW     = 0,
   parameter int unsigned c_CAR_WIDTH    = 1,
   parameter int unsigned c_INIT_LIVES   = 3,
   parameter int unsigned c_DEATH_FRAMES = 60
) (
   input logic               i_Clk,
   input logic               i_Rst,
   frogger_game_fsm_if.slave bus
);

   localparam score_t     c_LIMIT      = score_t'(c_SCORE_LIMIT);
   localparam tile_t      c_GOAL       = tile_t'(c_GOAL_ROW);
   localparam logic [7:0] c_LAST_FRAME = 8'(c_DEATH_FRAMES - 1);

   logic       vsync_q, tick_q, start_q, start_edge_q;
   logic       hit_1, hit_2, hit_3, hit;
   state_t     state_q, state_d;
   score_t     score_q, score_d;
   logic [7:0] count_q, count_d;
   logic       frog_reset_q, frog_reset_d;
   logic       game_active_q;

`ifdef FROGGER_LIVES_EN
   localparam logic [1:0] c_LIVES = 2'(c_INIT_LIVES);
   logic [1:0] lives_q, lives_d;
`endif

   car_collision_check #(.c_CAR_WIDTH(c_CAR_WIDTH)) u_car_1 (
      .i_Frogger_X(bus.i_Frogger_X), .i_Frogger_Y(bus.i_Frogger_Y),
      .i_Car_X(bus.i_Car_X_1), .i_Car_Y(bus.i_Car_Y_1), .o_Hit(hit_1)
   );
   car_collision_check #(.c_CAR_WIDTH(c_CAR_WIDTH)) u_car_2 (
      .i_Frogger_X(bus.i_Frogger_X), .i_Frogger_Y(bus.i_Frogger_Y),
      .i_Car_X(bus.i_Car_X_2), .i_Car_Y(bus.i_Car_Y_2), .o_Hit(hit_2)
   );
   car_collision_check #(.c_CAR_WIDTH(c_CAR_WIDTH)) u_car_3 (
      .i_Frogger_X(bus.i_Frogger_X), .i_Frogger_Y(bus.i_Frogger_Y),
      .i_Car_X(bus.i_Car_X_3), .i_Car_Y(bus.i_Car_Y_3), .o_Hit(hit_3)
   );

   assign hit = hit_1 | hit_2 | hit_3;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         vsync_q      <= 1'b0;
         tick_q       <= 1'b0;
         start_q      <= 1'b0;
         start_edge_q <= 1'b0;
      end else begin
         vsync_q      <= bus.i_VSync;
         tick_q       <= bus.i_VSync & ~vsync_q;
         start_q      <= bus.i_Game_Start;
         start_edge_q <= bus.i_Game_Start & ~start_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      count_d      = count_q;
      frog_reset_d = 1'b0;
`ifdef FROGGER_LIVES_EN
      lives_d      = lives_q;
`endif
      case (state_q)
         IDLE, GAME_OVER, WIN: begin
            if (start_edge_q) state_d = CLEANUP;
         end
         CLEANUP: state_d = RUNNING;
         RUNNING: begin
            if (tick_q) begin
               if (hit) begin
                  state_d = HIT;
                  count_d = 8'd0;
               end else if (bus.i_Frogger_Y == c_GOAL) begin
                  if (score_q < c_LIMIT) score_d = score_q + score_t'(1);
                  frog_reset_d = 1'b1;
                  if (score_d == c_LIMIT) state_d = WIN;
               end
            end
         end
         HIT: begin
            if (tick_q) begin
               if (count_q == c_LAST_FRAME) begin
`ifdef FROGGER_LIVES_EN
                  lives_d = lives_q - 2'd1;
                  if (lives_d == 2'd0) begin
                     state_d = GAME_OVER;
                  end else begin
                     state_d      = RUNNING;
                     frog_reset_d = 1'b1;
                  end
`else
                  state_d = GAME_OVER;
`endif
               end else begin
                  count_d = count_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs are registered, so CLEANUP's values are loaded on the way in.
      if (state_d == CLEANUP) begin
         score_d      = '0;
         frog_reset_d = 1'b1;
`ifdef FROGGER_LIVES_EN
         lives_d      = c_LIVES;
`endif
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q       <= IDLE;
         score_q       <= '0;
         count_q       <= 8'd0;
         frog_reset_q  <= 1'b0;
         game_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         score_q       <= score_d;
         count_q       <= count_d;
         frog_reset_q  <= frog_reset_d;
         game_active_q <= (state_d == RUNNING);
      end
   end

`ifdef FROGGER_LIVES_EN
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) lives_q <= c_LIVES;
      else       lives_q <= lives_d;
   end
   assign bus.o_Lives = lives_q;
`else
   assign bus.o_Lives = 2'd1;
`endif

   assign bus.o_State       = state_q;
   assign bus.o_Score       = score_q;
   assign bus.o_Frog_Reset  = frog_reset_q;
   assign bus.o_Game_Active = game_active_q;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Bench for frogger_game_fsm: directed scenarios plus randomized frames against a game-rule model.
module tb_frogger_game_fsm;

   localparam int W = 2, INIT = 3, DEATH = 60, LIMIT = 99, GOAL = 0;
   localparam int S_IDLE = 0, S_RUN = 1, S_HIT = 2, S_GO = 3, S_WIN = 4, S_CLEAN = 5;
`ifdef FROGGER_LIVES_EN
   localparam int INIT_OUT = INIT;
`else
   localparam int INIT_OUT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   frogger_game_fsm_if bus ();

   frogger_game_fsm #(
      .c_SCORE_LIMIT(LIMIT), .c_GOAL_ROW(GOAL), .c_CAR_WIDTH(W),
      .c_INIT_LIVES(INIT), .c_DEATH_FRAMES(DEATH)
   ) dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0, pulses = 0, consec = 0;
   bit fr_prev = 1'b0;
   int fx, fy;
   int cx[3], cy[3];
   int m_state, m_score, m_lives, m_hit_frames;

   task automatic apply_pos();
      bus.i_Frogger_X = 6'(fx); bus.i_Frogger_Y = 6'(fy);
      bus.i_Car_X_1 = 6'(cx[0]); bus.i_Car_Y_1 = 6'(cy[0]);
      bus.i_Car_X_2 = 6'(cx[1]); bus.i_Car_Y_2 = 6'(cy[1]);
      bus.i_Car_X_3 = 6'(cx[2]); bus.i_Car_Y_3 = 6'(cy[2]);
   endtask

   task automatic set_pos(input int x, input int y);
      fx = x; fy = y;
      for (int k = 0; k < 3; k++) begin cx[k] = 10 * k; cy[k] = 50 + k; end
      apply_pos();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.o_Frog_Reset) begin
         pulses++;
         if (fr_prev) consec++;
      end
      fr_prev = bus.o_Frog_Reset;
   endtask

   task automatic frame();
      bus.i_VSync = 1'b1;
      step();
      bus.i_VSync = 1'b0;
      repeat (3) step();
   endtask

   task automatic press_start();
      bus.i_Game_Start = 1'b1;
      repeat (3) step();
      bus.i_Game_Start = 1'b0;
      step();
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_score = 0; m_lives = INIT; m_hit_frames = 0;
   endtask

   task automatic model_start(output int ep);
      ep = 0;
      if (m_state == S_IDLE || m_state == S_GO || m_state == S_WIN) begin
         m_state = S_RUN; m_score = 0; m_lives = INIT; ep = 1;
      end
   endtask

   task automatic model_frame(output int ep);
      bit h;
      ep = 0;
      h = 1'b0;
      for (int k = 0; k < 3; k++)
         if (fy == cy[k] && fx >= cx[k] && fx < cx[k] + W) h = 1'b1;
      if (m_state == S_RUN) begin
         if (h) begin
            m_state = S_HIT; m_hit_frames = 0;
         end else if (fy == GOAL) begin
            if (m_score < LIMIT) m_score++;
            ep = 1;
            if (m_score == LIMIT) m_state = S_WIN;
         end
      end else if (m_state == S_HIT) begin
         m_hit_frames++;
         if (m_hit_frames == DEATH) begin
`ifdef FROGGER_LIVES_EN
            m_lives--;
            if (m_lives == 0) m_state = S_GO;
            else begin m_state = S_RUN; ep = 1; end
`else
            m_state = S_GO;
`endif
         end
      end
   endtask

   function automatic int model_lives_out();
`ifdef FROGGER_LIVES_EN
      return m_lives;
`else
      return 1;
`endif
   endfunction

   task automatic test_reset();
      bus.i_VSync = 1'b0; bus.i_Game_Start = 1'b0;
      set_pos(5, 14);
      rst = 1'b1;
      repeat (2) step();
      n_cmp++; if (bus.o_State !== 3'(S_IDLE)) begin n_err++; $display("FAIL reset_state got %0d exp %0d", bus.o_State, S_IDLE); end
      n_cmp++; if (bus.o_Game_Active !== 1'b0) begin n_err++; $display("FAIL reset_active got %0b exp 0", bus.o_Game_Active); end
      n_cmp++; if (bus.o_Score !== 7'd0) begin n_err++; $display("FAIL reset_score got %0d exp 0", bus.o_Score); end
      n_cmp++; if (bus.o_Lives !== 2'(INIT_OUT)) begin n_err++; $display("FAIL reset_lives got %0d exp %0d", bus.o_Lives, INIT_OUT); end
      n_cmp++; if (bus.o_Frog_Reset !== 1'b0) begin n_err++; $display("FAIL reset_frog_reset got %0b exp 0", bus.o_Frog_Reset); end
      rst = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_start();
      pulses = 0;
      bus.i_Game_Start = 1'b1;
      repeat (2) step();
      n_cmp++; if (bus.o_State !== 3'(S_CLEAN)) begin n_err++; $display("FAIL start_cleanup got %0d exp %0d", bus.o_State, S_CLEAN); end
      n_cmp++; if (bus.o_Frog_Reset !== 1'b1) begin n_err++; $display("FAIL start_frog_reset got %0b exp 1", bus.o_Frog_Reset); end
      step();
      n_cmp++; if (bus.o_State !== 3'(S_RUN)) begin n_err++; $display("FAIL start_running got %0d exp %0d", bus.o_State, S_RUN); end
      n_cmp++; if (bus.o_Game_Active !== 1'b1) begin n_err++; $display("FAIL start_active got %0b exp 1", bus.o_Game_Active); end
      n_cmp++; if (bus.o_Score !== 7'd0) begin n_err++; $display("FAIL start_score got %0d exp 0", bus.o_Score); end
      n_cmp++; if (bus.o_Lives !== 2'(INIT_OUT)) begin n_err++; $display("FAIL start_lives got %0d exp %0d", bus.o_Lives, INIT_OUT); end
      repeat (5) step();
      bus.i_Game_Start = 1'b0;
      step();
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL start_pulse_count got %0d exp 1", pulses); end
      n_cmp++; if (bus.o_State !== 3'(S_RUN)) begin n_err++; $display("FAIL start_held got %0d exp %0d", bus.o_State, S_RUN); end
   endtask

   task automatic test_goal();
      set_pos(5, 0);
      pulses = 0;
      frame();
      n_cmp++; if (bus.o_Score !== 7'd1) begin n_err++; $display("FAIL goal_score got %0d exp 1", bus.o_Score); end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL goal_pulse got %0d exp 1", pulses); end
      n_cmp++; if (bus.o_State !== 3'(S_RUN)) begin n_err++; $display("FAIL goal_state got %0d exp %0d", bus.o_State, S_RUN); end
   endtask

   task automatic test_hit_respawn();
      int exp_state, exp_lives, exp_pulses;
`ifdef FROGGER_LIVES_EN
      exp_state = S_RUN; exp_lives = 2; exp_pulses = 1;
`else
      exp_state = S_GO; exp_lives = 1; exp_pulses = 0;
`endif
      set_pos(7, 13);
      cx[0] = 6; cy[0] = 13;
      apply_pos();
      frame();
      n_cmp++; if (bus.o_State !== 3'(S_HIT)) begin n_err++; $display("FAIL hit_enter got %0d exp %0d", bus.o_State, S_HIT); end
      n_cmp++; if (bus.o_Game_Active !== 1'b0) begin n_err++; $display("FAIL hit_active got %0b exp 0", bus.o_Game_Active); end
      repeat (DEATH - 1) frame();
      n_cmp++; if (bus.o_State !== 3'(S_HIT)) begin n_err++; $display("FAIL hit_hold got %0d exp %0d", bus.o_State, S_HIT); end
      pulses = 0;
      frame();
      n_cmp++; if (bus.o_State !== 3'(exp_state)) begin n_err++; $display("FAIL hit_exit_state got %0d exp %0d", bus.o_State, exp_state); end
      n_cmp++; if (bus.o_Lives !== 2'(exp_lives)) begin n_err++; $display("FAIL hit_exit_lives got %0d exp %0d", bus.o_Lives, exp_lives); end
      n_cmp++; if (pulses !== exp_pulses) begin n_err++; $display("FAIL hit_exit_pulse got %0d exp %0d", pulses, exp_pulses); end
      fx = 8;
      apply_pos();
      frame();
      n_cmp++; if (bus.o_State !== 3'(exp_state)) begin n_err++; $display("FAIL no_hit_state got %0d exp %0d", bus.o_State, exp_state); end
      n_cmp++; if (bus.o_Score !== 7'd1) begin n_err++; $display("FAIL no_hit_score got %0d exp 1", bus.o_Score); end
   endtask

   task automatic test_game_over();
      int remaining, exp_lives;
`ifdef FROGGER_LIVES_EN
      remaining = 2; exp_lives = 0;
`else
      remaining = 0; exp_lives = 1;
`endif
      set_pos(7, 13);
      cx[0] = 6; cy[0] = 13;
      apply_pos();
      pulses = 0;
      for (int h = 0; h < remaining; h++) begin
         repeat (DEATH) frame();
         pulses = 0;
         frame();
      end
      n_cmp++; if (bus.o_State !== 3'(S_GO)) begin n_err++; $display("FAIL over_state got %0d exp %0d", bus.o_State, S_GO); end
      n_cmp++; if (bus.o_Lives !== 2'(exp_lives)) begin n_err++; $display("FAIL over_lives got %0d exp %0d", bus.o_Lives, exp_lives); end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL over_no_pulse got %0d exp 0", pulses); end
      set_pos(5, 0);
      frame();
      n_cmp++; if (bus.o_Score !== 7'd1) begin n_err++; $display("FAIL over_frozen_score got %0d exp 1", bus.o_Score); end
      n_cmp++; if (bus.o_State !== 3'(S_GO)) begin n_err++; $display("FAIL over_hold got %0d exp %0d", bus.o_State, S_GO); end
      bus.i_Game_Start = 1'b1;
      repeat (2) step();
      n_cmp++; if (bus.o_State !== 3'(S_CLEAN)) begin n_err++; $display("FAIL restart_cleanup got %0d exp %0d", bus.o_State, S_CLEAN); end
      n_cmp++; if (bus.o_Score !== 7'd0) begin n_err++; $display("FAIL restart_score got %0d exp 0", bus.o_Score); end
      n_cmp++; if (bus.o_Lives !== 2'(INIT_OUT)) begin n_err++; $display("FAIL restart_lives got %0d exp %0d", bus.o_Lives, INIT_OUT); end
      bus.i_Game_Start = 1'b0;
      repeat (2) step();
      n_cmp++; if (bus.o_State !== 3'(S_RUN)) begin n_err++; $display("FAIL restart_running got %0d exp %0d", bus.o_State, S_RUN); end
   endtask

   task automatic test_win();
      set_pos(5, 0);
      repeat (LIMIT - 1) frame();
      n_cmp++; if (bus.o_Score !== 7'(LIMIT - 1)) begin n_err++; $display("FAIL win_preset got %0d exp %0d", bus.o_Score, LIMIT - 1); end
      n_cmp++; if (bus.o_State !== 3'(S_RUN)) begin n_err++; $display("FAIL win_preset_state got %0d exp %0d", bus.o_State, S_RUN); end
      pulses = 0;
      frame();
      n_cmp++; if (bus.o_Score !== 7'(LIMIT)) begin n_err++; $display("FAIL win_score got %0d exp %0d", bus.o_Score, LIMIT); end
      n_cmp++; if (bus.o_State !== 3'(S_WIN)) begin n_err++; $display("FAIL win_state got %0d exp %0d", bus.o_State, S_WIN); end
      n_cmp++; if (bus.o_Game_Active !== 1'b0) begin n_err++; $display("FAIL win_active got %0b exp 0", bus.o_Game_Active); end
      repeat (3) frame();
      n_cmp++; if (bus.o_Score !== 7'(LIMIT)) begin n_err++; $display("FAIL win_saturate got %0d exp %0d", bus.o_Score, LIMIT); end
      n_cmp++; if (bus.o_State !== 3'(S_WIN)) begin n_err++; $display("FAIL win_hold got %0d exp %0d", bus.o_State, S_WIN); end
   endtask

   task automatic test_goal_hit_same();
      press_start();
      set_pos(5, 0);
      repeat (2) frame();
      set_pos(4, 0);
      cx[1] = 4; cy[1] = 0;
      apply_pos();
      frame();
      n_cmp++; if (bus.o_State !== 3'(S_HIT)) begin n_err++; $display("FAIL goal_hit_state got %0d exp %0d", bus.o_State, S_HIT); end
      n_cmp++; if (bus.o_Score !== 7'd2) begin n_err++; $display("FAIL goal_hit_score got %0d exp 2", bus.o_Score); end
      repeat (5) frame();
   endtask

   task automatic test_reset_mid_hit();
      n_cmp++; if (bus.o_State !== 3'(S_HIT)) begin n_err++; $display("FAIL mid_hit_pre got %0d exp %0d", bus.o_State, S_HIT); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.o_State !== 3'(S_IDLE)) begin n_err++; $display("FAIL mid_rst_state got %0d exp %0d", bus.o_State, S_IDLE); end
      n_cmp++; if (bus.o_Score !== 7'd0) begin n_err++; $display("FAIL mid_rst_score got %0d exp 0", bus.o_Score); end
      n_cmp++; if (bus.o_Lives !== 2'(INIT_OUT)) begin n_err++; $display("FAIL mid_rst_lives got %0d exp %0d", bus.o_Lives, INIT_OUT); end
      n_cmp++; if (bus.o_Frog_Reset !== 1'b0) begin n_err++; $display("FAIL mid_rst_pulse got %0b exp 0", bus.o_Frog_Reset); end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_random();
      int ep;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      model_reset();
      consec = 0;
      for (int i = 0; i < 800; i++) begin
         pulses = 0;
         if ($urandom_range(0, 7) == 0) begin
            press_start();
            model_start(ep);
         end else begin
            fy = int'($urandom_range(0, 3));
            fx = int'($urandom_range(0, 63));
            for (int k = 0; k < 3; k++) begin
               cy[k] = int'($urandom_range(0, 19));
               cx[k] = (fx - int'($urandom_range(0, 3))) & 63;
            end
            if ($urandom_range(0, 15) == 0) begin cx[0] = 62; fx = 63; cy[0] = fy; end
            apply_pos();
            frame();
            model_frame(ep);
         end
         n_cmp++; if (bus.o_State !== 3'(m_state)) begin n_err++; $display("FAIL rand_state[%0d] got %0d exp %0d", i, bus.o_State, m_state); end
         n_cmp++; if (bus.o_Score !== 7'(m_score)) begin n_err++; $display("FAIL rand_score[%0d] got %0d exp %0d", i, bus.o_Score, m_score); end
         n_cmp++; if (bus.o_Lives !== 2'(model_lives_out())) begin n_err++; $display("FAIL rand_lives[%0d] got %0d exp %0d", i, bus.o_Lives, model_lives_out()); end
         n_cmp++; if (pulses !== ep) begin n_err++; $display("FAIL rand_pulse[%0d] got %0d exp %0d", i, pulses, ep); end
      end
      n_cmp++; if (consec !== 0) begin n_err++; $display("FAIL back_to_back_pulses got %0d exp 0", consec); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_goal();
      test_hit_respawn();
      test_game_over();
      test_win();
      test_goal_hit_same();
      test_reset_mid_hit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
